// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
// Bundles the fetch unit's connections to the register file (PC, pc_inc),
// instruction memory (req/rsp) and decoder (valid/ready).
//   master : the fetch unit side (drives requests, pc_inc and the instruction stream)
//   slave  : the environment side (register file, memory, decoder)
// Signals:
//   pc_addr        current PC from the register file
//   pc_inc         one-cycle pulse asking the register file to add 2 to PC
//   mem_req_*      read request (valid/ready/addr)
//   mem_rsp_*      read response (valid/data), one per accepted request
//   flush          discard buffered and in-flight instructions
//   instr_*        head of the instruction buffer toward decode
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_inc;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              flush;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        input  pc_addr,
        output pc_inc,
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_addr,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        input  flush,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        output pc_addr,
        input  pc_inc,
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_addr,
        output mem_rsp_valid,
        output mem_rsp_data,
        output flush,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Samples the PC, issues one instruction-memory read at a time, pulses pc_inc
// for every accepted request and buffers fetched words toward the decoder.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous, active-high reset
//   bus   instr_fetch_unit_if.master (PC, memory req/rsp, flush, decode stream)
//
// state  | meaning
// BOOT   | pulse pc_inc once to move PC from 0xFFFE to 0x0000
// SETTLE | let PC settle; capture it as the next address when the buffer has room
// REQ    | request held on the memory port until accepted
// WAIT   | one request outstanding; push or drop its response
module instr_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input logic clk,
    input logic rst,
    instr_fetch_unit_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {BOOT, SETTLE, REQ, WAIT} state_t;

    state_t            state_q, state_d;
    logic              pc_inc_q, pc_inc_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [CNT_W-1:0]  remaining;

    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];

    logic accept;
    logic push;
    logic pop;

    assign accept = req_valid_q & bus.mem_req_ready;
    assign pop    = head_valid_q & bus.instr_ready & ~bus.flush;
    assign push   = (state_q == WAIT) & bus.mem_rsp_valid & ~drop_q & ~bus.flush;

    always_comb begin
        state_d      = state_q;
        pc_inc_d     = 1'b0;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        drop_d       = drop_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_pc_d    = head_pc_q;
        remaining    = count_q - CNT_W'(pop);

        if (bus.flush) begin
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            head_valid_d = 1'b0;
        end else begin
            count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d     = wr_ptr_q + PTR_W'(push);
            head_valid_d = (count_d != '0);
            // Head output is registered: take the next stored entry, or the
            // incoming word directly when the buffer drains in this cycle.
            if (remaining != '0) begin
                head_data_d = fifo_data[rd_ptr_d];
                head_pc_d   = fifo_pc[rd_ptr_d];
            end else if (push) begin
                head_data_d = bus.mem_rsp_data;
                head_pc_d   = req_addr_q;
            end
        end

        case (state_q)
            BOOT: begin
                // Two cycles: raise pc_inc, then leave once it has been seen.
                if (!pc_inc_q) begin
                    pc_inc_d = 1'b1;
                end else begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (count_d < CNT_W'(DEPTH)) begin
                    req_addr_d  = bus.pc_addr;
                    req_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (accept) begin
                    req_valid_d = 1'b0;
                    pc_inc_d    = 1'b1;
                    drop_d      = bus.flush;
                    state_d     = WAIT;
                end else if (bus.flush) begin
                    req_valid_d = 1'b0;
                    state_d     = SETTLE;
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    drop_d  = 1'b0;
                    state_d = SETTLE;
                end else if (bus.flush) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_inc_q     <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            drop_q       <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_inc_q     <= pc_inc_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            drop_q       <= drop_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            head_pc_q    <= head_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_data[wr_ptr_q] <= bus.mem_rsp_data;
            fifo_pc[wr_ptr_q]   <= req_addr_q;
        end
    end

    assign bus.pc_inc        = pc_inc_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.instr_valid   = head_valid_q;
    assign bus.instr_data    = head_data_q;
    assign bus.instr_pc      = head_pc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Drives the fetch unit with a register-file model (PC resets to 0xFFFE, +2 per
// pc_inc), a memory model with programmable response latency, and directed
// decoder/flush/reset stimulus. An expected-instruction queue tracks which
// responses must reach the decoder and in what order.
module tb_instr_fetch_unit;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } ent_t;

    logic clk;
    logic rst;

    instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] tb_pc;
    int          rsp_lat = 1;
    int          rsp_cnt = 0;
    logic [15:0] rsp_pend_addr;
    bit          override_en = 0;
    logic [15:0] override_data;

    ent_t        exp_q[$];
    bit          m_out = 0;
    bit          m_drop = 0;
    logic [15:0] m_addr;
    int          since_rst = 0;
    bit          exp_pc_inc = 0;
    bit          started = 0;

    int          cycle_n = 0;
    int          pc_inc_cnt = 0;
    logic [15:0] req_log[$];
    int          acc_cyc[$];
    ent_t        pop_log[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_n);
        end
    endtask

    task automatic tick();
        logic s_accept, s_pcinc, s_pop, s_rsp, s_flush, s_rst;
        logic [15:0] s_addr, s_rdata;
        ent_t s_head;
        s_accept = bus.mem_req_valid & bus.mem_req_ready;
        s_pcinc  = bus.pc_inc;
        s_pop    = bus.instr_valid & bus.instr_ready;
        s_rsp    = bus.mem_rsp_valid;
        s_rdata  = bus.mem_rsp_data;
        s_flush  = bus.flush;
        s_rst    = rst;
        s_addr   = bus.mem_req_addr;
        s_head   = {bus.instr_pc, bus.instr_data};
        @(posedge clk);
        #1;
        cycle_n++;
        started = 1;
        if (s_pcinc) pc_inc_cnt++;
        if (s_accept) begin
            req_log.push_back(s_addr);
            acc_cyc.push_back(cycle_n);
        end
        if (s_pop) pop_log.push_back(s_head);

        // register file
        if (s_rst) tb_pc = 16'hFFFE;
        else if (s_pcinc) tb_pc = tb_pc + 16'd2;
        bus.pc_addr = tb_pc;

        // expected instruction stream
        if (s_rst) begin
            exp_q.delete();
            m_out = 0;
            m_drop = 0;
            since_rst = 0;
            exp_pc_inc = 0;
        end else begin
            since_rst++;
            exp_pc_inc = s_accept || (since_rst == 1);
            if (s_flush) exp_q.delete();
            else if (s_pop && exp_q.size() != 0) void'(exp_q.pop_front());
            if (m_out && s_rsp) begin
                if (!m_drop && !s_flush) exp_q.push_back({m_addr, s_rdata});
                m_out = 0;
                m_drop = 0;
            end else if (m_out && s_flush) begin
                m_drop = 1;
            end
            if (s_accept) begin
                m_out = 1;
                m_drop = s_flush;
                m_addr = s_addr;
            end
        end

        // memory responder, independent of the fetch unit's reset
        bus.mem_rsp_valid = 1'b0;
        if (s_accept) begin
            rsp_cnt = rsp_lat;
            rsp_pend_addr = s_addr;
        end
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = override_en ? override_data : mem_word(rsp_pend_addr);
                override_en = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("pc_inc", 32'(bus.pc_inc), 32'(exp_pc_inc));
            chk("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("instr_data", 32'(bus.instr_data), 32'(exp_q[0].data));
                chk("instr_pc", 32'(bus.instr_pc), 32'(exp_q[0].pc));
            end
            if (bus.mem_req_valid) begin
                chk("req_addr_is_pc", 32'(bus.mem_req_addr), 32'(tb_pc));
                chk("req_while_outstanding", 32'(m_out), 32'd0);
                chk("req_buffer_room", 32'(exp_q.size() < DEPTH), 32'd1);
            end
            chk("no_beef", 32'(bus.instr_data == 16'hBEEF), 32'd0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        override_en = 0;
        tick();
        tick();
        rst = 1'b0;
        req_log.delete();
        acc_cyc.delete();
        pop_log.delete();
        pc_inc_cnt = 0;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k;
        k = 0;
        while (req_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (req_log.size() < n) chk("wait_accept_timeout", 32'(req_log.size()), 32'(n));
    endtask

    initial begin
        rst = 1'b1;
        tb_pc = 16'hFFFE;
        bus.pc_addr = 16'hFFFE;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = 16'h0000;
        bus.flush = 1'b0;
        bus.instr_ready = 1'b1;

        // 1: free-running fetch
        rsp_lat = 1;
        do_reset();
        tick();
        chk("t1_boot_pc_inc", 32'(bus.pc_inc), 32'd1);
        repeat (13) tick();
        chk("t1_addr0", 32'(req_log[0]), 32'h0000);
        chk("t1_addr1", 32'(req_log[1]), 32'h0002);
        chk("t1_addr2", 32'(req_log[2]), 32'h0004);
        chk("t1_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        chk("t1_pop0_pc", 32'(pop_log[0].pc), 32'h0000);
        chk("t1_pop0_data", 32'(pop_log[0].data), 32'h005A);
        chk("t1_pop1_data", 32'(pop_log[1].data), 32'h025A);

        // 2: decoder stalled, buffer fills
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (25) tick();
        chk("t2_fetches", 32'(req_log.size()), 32'd2);
        chk("t2_pc_inc_cnt", 32'(pc_inc_cnt), 32'd3);
        chk("t2_req_idle", 32'(bus.mem_req_valid), 32'd0);
        chk("t2_head_pc", 32'(bus.instr_pc), 32'h0000);
        bus.instr_ready = 1'b1;
        wait_acc(3, 20);
        chk("t2_next_addr", 32'(req_log[2]), 32'h0004);

        // 3: memory back-pressure
        bus.mem_req_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10 && !bus.mem_req_valid; k++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid_held", 32'(bus.mem_req_valid), 32'd1);
            chk("t3_addr_held", 32'(bus.mem_req_addr), 32'h0000);
            chk("t3_no_pc_inc", 32'(bus.pc_inc), 32'd0);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();
        chk("t3_pc_inc_after_accept", 32'(bus.pc_inc), 32'd1);
        repeat (6) tick();

        // 4: flush while waiting for 0xBEEF
        do_reset();
        rsp_lat = 2;
        override_data = 16'hBEEF;
        override_en = 1;
        wait_acc(1, 20);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        rsp_lat = 1;
        tick();
        tick();
        chk("t4_instr_valid", 32'(bus.instr_valid), 32'd0);
        wait_acc(2, 20);
        chk("t4_next_addr", 32'(req_log[1]), 32'h0002);
        repeat (8) tick();

        // 5: reset while waiting, response arrives a cycle later
        do_reset();
        rsp_lat = 2;
        wait_acc(1, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_pc_inc", 32'(bus.pc_inc), 32'd0);
        chk("t5_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("t5_rst_req_addr", 32'(bus.mem_req_addr), 32'd0);
        chk("t5_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("t5_rst_instr_data", 32'(bus.instr_data), 32'd0);
        chk("t5_rst_instr_pc", 32'(bus.instr_pc), 32'd0);
        tick();
        chk("t5_boot_pulse", 32'(bus.pc_inc), 32'd1);
        chk("t5_no_push", 32'(bus.instr_valid), 32'd0);
        rsp_lat = 1;
        repeat (10) tick();

        // 6: push and pop in the same cycle with one entry buffered
        bus.instr_ready = 1'b0;
        do_reset();
        wait_acc(2, 20);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk("t6_valid", 32'(bus.instr_valid), 32'd1);
        chk("t6_head_pc", 32'(bus.instr_pc), 32'h0002);
        chk("t6_head_data", 32'(bus.instr_data), 32'h025A);
        chk("t6_popped_old", 32'(pop_log[0].pc), 32'h0000);
        bus.instr_ready = 1'b1;
        tick();
        chk("t6_count_was_one", 32'(bus.instr_valid), 32'd0);
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
